huff_dec_sequencer: RTL and testbench

- Frame-level controller for the Huffman decode datapath (parallel-to-serial stage -> Huffman decoder -> output concatenator).
- Accepts compressed 32-bit words from an upstream requester over a valid/ready handshake and issues one-cycle load strobes to the serializer only once the previous word has fully shifted out.
- After the last word of a frame, waits for the decode pipeline to drain, then pulses frame_done with the count of decoded 32-bit output words.

---
 rtl/huff_pkg.sv | 22 ++
 rtl/huff_seq_cnt.sv | 30 +++
 rtl/huff_dec_sequencer.sv | 141 ++++++++++++++
 tb/tb_huff_dec_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/huff_pkg.sv
// Shared types and helpers for the Huffman decode sequencer.
// The optional drain-extend feature is enabled by defining SEQ_DRAIN_EXTEND_EN.
package huff_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    DRAIN,
    DONE
  } state_e;

  localparam int DATA_W_DEF       = 32;
  localparam int SHIFT_CYCLES_DEF = 32;
  localparam int DRAIN_CYCLES_DEF = 8;

  // Counter width for a count of n cycles; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/huff_seq_cnt.sv
// Clearable up-counter that stops at TERM-1 and flags that terminal count.
module huff_seq_cnt
  import huff_pkg::*;
#(
  parameter int TERM = 32,
  parameter int W    = cnt_width(TERM)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [W-1:0] cnt_q;

  assign tc_o = (cnt_q == W'(TERM - 1));

  // Clear wins over enable; callers gate enable at terminal count to hold there.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/huff_dec_sequencer.sv
// Frame-level controller feeding the serializer and counting decoded words.
// Define SEQ_DRAIN_EXTEND_EN to restart the drain window on every out_strobe.
module huff_dec_sequencer
  import huff_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int SHIFT_CYCLES = SHIFT_CYCLES_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              dec_load,
  output logic [DATA_W-1:0] dec_data,
  input  logic              out_strobe,
  output logic              busy,
  output logic              frame_done,
  output logic [CNT_W-1:0]  frame_words
);

  state_e             state_q;
  logic               dec_load_q;
  logic [DATA_W-1:0]  dec_data_q;
  logic               last_q;
  logic               frame_done_q;
  logic [CNT_W-1:0]   word_cnt_q;
  logic [CNT_W-1:0]   frame_words_q;

  logic               shift_tc;
  logic               drain_tc;
  logic               accept;
  logic               extend_hit;
  logic               drain_done;
  logic [CNT_W-1:0]   word_cnt_inc;
  logic [CNT_W-1:0]   word_total;

  // The shift counter parks at its terminal count, which doubles as the wait sub-mode.
  huff_seq_cnt #(
    .TERM (SHIFT_CYCLES)
  ) u_shift_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (state_q != SHIFT),
    .en_i   (!shift_tc),
    .tc_o   (shift_tc)
  );

  huff_seq_cnt #(
    .TERM (DRAIN_CYCLES)
  ) u_drain_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  ((state_q != DRAIN) || extend_hit),
    .en_i   (1'b1),
    .tc_o   (drain_tc)
  );

`ifdef SEQ_DRAIN_EXTEND_EN
  assign extend_hit = (state_q == DRAIN) && out_strobe;
`else
  assign extend_hit = 1'b0;
`endif

  assign drain_done = drain_tc && !extend_hit;

  // Ready is held low while reset is asserted even though the state reads IDLE.
  assign in_ready = rst && ((state_q == IDLE) ||
                            ((state_q == SHIFT) && shift_tc && !last_q));
  assign accept   = in_valid && in_ready;

  assign word_cnt_inc = (word_cnt_q == '1) ? word_cnt_q : word_cnt_q + 1'b1;
  assign word_total   = out_strobe ? word_cnt_inc : word_cnt_q;

  assign busy        = (state_q != IDLE);
  assign dec_load    = dec_load_q;
  assign dec_data    = dec_data_q;
  assign frame_done  = frame_done_q;
  assign frame_words = (state_q == DONE) ? word_total : frame_words_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      dec_load_q    <= 1'b0;
      dec_data_q    <= '0;
      last_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      word_cnt_q    <= '0;
      frame_words_q <= '0;
    end else begin
      dec_load_q   <= 1'b0;
      frame_done_q <= 1'b0;
      if (state_q != IDLE) begin
        word_cnt_q <= word_total;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            dec_data_q <= in_data;
            last_q     <= in_last;
            word_cnt_q <= CNT_W'(out_strobe);
            dec_load_q <= 1'b1;
            state_q    <= LOAD;
          end
        end
        LOAD: begin
          state_q <= SHIFT;
        end
        SHIFT: begin
          if (shift_tc) begin
            if (last_q) begin
              state_q <= DRAIN;
            end else if (accept) begin
              dec_data_q <= in_data;
              last_q     <= in_last;
              dec_load_q <= 1'b1;
              state_q    <= LOAD;
            end
          end
        end
        DRAIN: begin
          if (drain_done) begin
            frame_done_q <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: begin
          frame_words_q <= word_total;
          state_q       <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_huff_dec_sequencer.sv
// Directed self-checking bench for huff_dec_sequencer with hand-computed cycle numbers.
module tb_huff_dec_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        out_strobe;

  logic        in_ready, dec_load, busy, frame_done;
  logic [31:0] dec_data;
  logic [15:0] frame_words;

  logic        in_ready_s, dec_load_s, busy_s, frame_done_s;
  logic [31:0] dec_data_s;
  logic [1:0]  frame_words_s;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int loadCyc[$];
  logic [31:0] loadData[$];
  int doneCnt = 0;
  int lockstepBad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  huff_dec_sequencer u_dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .dec_load    (dec_load),
    .dec_data    (dec_data),
    .out_strobe  (out_strobe),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_words (frame_words)
  );

  // Narrow-counter copy to exercise word-count saturation.
  huff_dec_sequencer #(.CNT_W(2)) u_dut_sat (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready_s),
    .dec_load    (dec_load_s),
    .dec_data    (dec_data_s),
    .out_strobe  (out_strobe),
    .busy        (busy_s),
    .frame_done  (frame_done_s),
    .frame_words (frame_words_s)
  );

  always @(negedge clk) begin
    if (dec_load) begin
      loadCyc.push_back(cyc);
      loadData.push_back(dec_data);
    end
    if (frame_done) doneCnt++;
    if ({in_ready_s, dec_load_s, dec_data_s, busy_s, frame_done_s} !==
        {in_ready, dec_load, dec_data, busy, frame_done}) lockstepBad++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offers one word and returns the cycle in which the handshake happened.
  task automatic applyStimulus(input logic [31:0] data, input logic last, output int accCyc);
    bit got = 0;
    in_data  = data;
    in_last  = last;
    in_valid = 1'b1;
    accCyc   = -1;
    for (int i = 0; i < 300 && !got; i++) begin
      if (in_ready) begin
        accCyc = cyc;
        got = 1;
      end
      tick();
    end
    if (!got) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic waitDone(output int dc, output logic [15:0] fw, output logic [1:0] fws);
    bit got = 0;
    dc  = -1;
    fw  = '0;
    fws = '0;
    for (int i = 0; i < 300 && !got; i++) begin
      if (frame_done) begin
        dc  = cyc;
        fw  = frame_words;
        fws = frame_words_s;
        got = 1;
      end else begin
        tick();
      end
    end
    if (!got) checkOutput("done_timeout", 0, 1);
  endtask

  initial begin
    int t, t1, t2, t3, ta, tb, d, bad, bad2;
    logic [15:0] fw;
    logic [1:0]  fws;
    logic [31:0] expData[3];

    rst = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_strobe = 1'b0;
    #3;
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_dec_load", dec_load, 0);
    checkOutput("rst_dec_data", dec_data, 0);
    checkOutput("rst_frame_done", frame_done, 0);
    checkOutput("rst_frame_words", frame_words, 0);
    tick(); tick();
    rst = 1'b1;
    tick();
    checkOutput("idle_in_ready", in_ready, 1);
    checkOutput("idle_busy", busy, 0);

    // Single word frame with three strobes during the shift.
    loadCyc.delete(); loadData.delete();
    applyStimulus(32'hC0DE0001, 1'b1, t);
    in_valid = 1'b0;
    checkOutput("t1_load_next", dec_load, 1);
    checkOutput("t1_dec_data", dec_data, 32'hC0DE0001);
    bad = 0; bad2 = 0;
    while (cyc < t + 42) begin
      if (in_ready) bad++;
      if (!busy) bad2++;
      out_strobe = (cyc == t + 5) || (cyc == t + 20) || (cyc == t + 30);
      tick();
    end
    out_strobe = 1'b0;
    checkOutput("t1_ready_low", bad, 0);
    checkOutput("t1_busy_high", bad2, 0);
    checkOutput("t1_load_count", loadCyc.size(), 1);
    checkOutput("t1_load_cycle", (loadCyc.size() > 0) ? loadCyc[0] : -1, t + 1);
    waitDone(d, fw, fws);
    checkOutput("t1_done_cycle", d, t + 42);
    checkOutput("t1_words", fw, 3);
    checkOutput("t1_ready_in_done", in_ready, 0);
    tick();
    checkOutput("t1_done_one_cycle", frame_done, 0);
    checkOutput("t1_back_idle", in_ready, 1);

    // Three back-to-back words with valid held high.
    loadCyc.delete(); loadData.delete();
    expData[0] = 32'hA5A5A5A5; expData[1] = 32'h12345678; expData[2] = 32'hFFFFFFFF;
    applyStimulus(expData[0], 1'b0, t1);
    applyStimulus(expData[1], 1'b0, t2);
    applyStimulus(expData[2], 1'b1, t3);
    in_valid = 1'b0;
    checkOutput("t2_gap12", t2 - t1, 33);
    checkOutput("t2_gap23", t3 - t2, 33);
    waitDone(d, fw, fws);
    checkOutput("t2_done_cycle", d, t3 + 42);
    checkOutput("t2_words", fw, 0);
    checkOutput("t2_load_count", loadCyc.size(), 3);
    if (loadCyc.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        checkOutput($sformatf("t2_load_cyc%0d", k), loadCyc[k], t1 + 1 + 33 * k);
        checkOutput($sformatf("t2_load_data%0d", k), loadData[k], expData[k]);
      end
    end
    tick();

    // Requester stalls ten cycles in the wait sub-mode, two strobes meanwhile.
    loadCyc.delete(); loadData.delete();
    applyStimulus(32'h33333333, 1'b0, ta);
    in_valid = 1'b0;
    while (cyc < ta + 33) tick();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!in_ready) bad++;
      out_strobe = (i == 2) || (i == 6);
      tick();
    end
    out_strobe = 1'b0;
    checkOutput("t3_stall_ready", bad, 0);
    checkOutput("t3_no_extra_load", loadCyc.size(), 1);
    applyStimulus(32'h44444444, 1'b1, tb);
    in_valid = 1'b0;
    checkOutput("t3_accept_cycle", tb, ta + 43);
    checkOutput("t3_load_next", dec_load, 1);
    checkOutput("t3_dec_data", dec_data, 32'h44444444);
    waitDone(d, fw, fws);
    checkOutput("t3_done_cycle", d, tb + 42);
    checkOutput("t3_words", fw, 2);
    tick();

    // Strobe coincident with the first accept; previous count must hold meanwhile.
    out_strobe = 1'b1;
    applyStimulus(32'h55550000, 1'b1, t);
    out_strobe = 1'b0;
    in_valid = 1'b0;
    bad = 0;
    while (cyc < t + 42) begin
      if (frame_words !== 16'd2) bad++;
      out_strobe = (cyc == t + 10) || (cyc == t + 30);
      tick();
    end
    out_strobe = 1'b0;
    checkOutput("t4_prev_words_held", bad, 0);
    waitDone(d, fw, fws);
    checkOutput("t4_done_cycle", d, t + 42);
    checkOutput("t4_words", fw, 3);
    tick(); tick(); tick();
    checkOutput("t4_words_held", frame_words, 3);

    // Reset in the middle of SHIFT, then a fresh frame that saturates the narrow copy.
    applyStimulus(32'hDEADBEEF, 1'b1, t);
    in_valid = 1'b0;
    while (cyc < t + 10) tick();
    #1 rst = 1'b0;
    #1;
    checkOutput("t5_rst_in_ready", in_ready, 0);
    checkOutput("t5_rst_busy", busy, 0);
    checkOutput("t5_rst_dec_load", dec_load, 0);
    checkOutput("t5_rst_dec_data", dec_data, 0);
    checkOutput("t5_rst_frame_words", frame_words, 0);
    bad = doneCnt;
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 60; i++) tick();
    checkOutput("t5_no_done", doneCnt - bad, 0);
    applyStimulus(32'h0F0F0F0F, 1'b1, t2);
    in_valid = 1'b0;
    checkOutput("t5_dec_data", dec_data, 32'h0F0F0F0F);
    while (cyc < t2 + 42) begin
      out_strobe = (cyc == t2 + 3) || (cyc == t2 + 5) || (cyc == t2 + 7) ||
                   (cyc == t2 + 9) || (cyc == t2 + 11);
      tick();
    end
    out_strobe = 1'b0;
    waitDone(d, fw, fws);
    checkOutput("t5_done_cycle", d, t2 + 42);
    checkOutput("t5_words", fw, 5);
    checkOutput("t5_words_saturated", fws, 3);
    tick();

    // Strobes at drain cycles 2 and 6.
    applyStimulus(32'h55AA55AA, 1'b1, t);
    in_valid = 1'b0;
    while (cyc < t + 42) begin
      out_strobe = (cyc == t + 36) || (cyc == t + 40);
      tick();
    end
    out_strobe = 1'b0;
    waitDone(d, fw, fws);
`ifdef SEQ_DRAIN_EXTEND_EN
    checkOutput("t6_done_cycle", d, t + 34 + 15);
`else
    checkOutput("t6_done_cycle", d, t + 34 + 8);
`endif
    checkOutput("t6_words", fw, 2);
    tick();

    checkOutput("lockstep", lockstepBad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
